leitor_jogada: RTL and testbench

LEITOR_JOGADA -- requirements
Module: leitor_jogada

---
 rtl/leitor_jogada_pkg.sv | 22 ++
 rtl/leitor_jogada_contador.sv | 23 ++
 rtl/leitor_jogada.sv | 154 +++++++++++++++
 tb/tb_leitor_jogada.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/leitor_jogada_pkg.sv
// Shared state encodings for the play reader, also used by the game control unit.
// Any change to these values changes what db_estado shows on the debug display.
package leitor_jogada_pkg;

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    ESPERA_SOLTA = 3'd1,
    AGUARDA      = 3'd2,
    FILTRA       = 3'd3,
    REGISTRA     = 3'd4,
    SOLTA        = 3'd5,
    ESGOTADO     = 3'd6
  } estado_t;

  localparam int BOTOES_W = 4;

  // Counter width for a modulus m, never narrower than one bit.
  function automatic int largura(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/leitor_jogada_contador.sv
// Generic counter with synchronous clear and enable; saturates at M-1 instead of wrapping.
module contador_m #(
  parameter int M = 4,
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor
);

  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      valor <= '0;
    end else if (conta && (valor != ULTIMO)) begin
      valor <= valor + W'(1);
    end
  end

endmodule

// File: rtl/leitor_jogada.sv
// Reads one debounced button press per play and compares it with the expected play.
// Outputs come from registers or from the state register only, never from botoes.
module leitor_jogada
  import leitor_jogada_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 5000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [BOTOES_W-1:0] botoes,
  input  logic [BOTOES_W-1:0] esperado,
  output logic                tem_jogada,
  output logic [BOTOES_W-1:0] jogada,
  output logic                igual,
  output logic                invalida,
  output logic                timeout,
  output logic [2:0]          db_estado
);

  // The filter counter reaches DEBOUNCE so the press is confirmed DEBOUNCE+1 edges after capture.
  localparam int FILTRO_M = DEBOUNCE + 1;
  localparam int FILTRO_W = largura(FILTRO_M);
  localparam int TEMPO_W  = largura(TIMEOUT);

  localparam logic [FILTRO_W-1:0] FILTRO_FIM = FILTRO_W'(DEBOUNCE);
  localparam logic [FILTRO_W-1:0] SOLTA_FIM  = FILTRO_W'(DEBOUNCE - 1);
  localparam logic [TEMPO_W-1:0]  TEMPO_FIM  = TEMPO_W'(TIMEOUT - 1);

  estado_t estado_reg, estado_next;

  logic [BOTOES_W-1:0] candidato_reg;
  logic [BOTOES_W-1:0] jogada_reg;
  logic                igual_reg;
  logic                invalida_reg;

  logic zera_t, conta_t, zera_f, conta_f;
  logic carrega, registra;

  logic [FILTRO_W-1:0] filtro_valor;
  logic [TEMPO_W-1:0]  tempo_valor;

  contador_m #(.M(FILTRO_M), .W(FILTRO_W)) u_filtro (
    .clock (clock),
    .reset (reset),
    .zera  (zera_f),
    .conta (conta_f),
    .valor (filtro_valor)
  );

  contador_m #(.M(TIMEOUT), .W(TEMPO_W)) u_tempo (
    .clock (clock),
    .reset (reset),
    .zera  (zera_t),
    .conta (conta_t),
    .valor (tempo_valor)
  );

  always_comb begin
    estado_next = estado_reg;
    zera_t      = 1'b0;
    conta_t     = 1'b0;
    zera_f      = 1'b0;
    conta_f     = 1'b0;
    carrega     = 1'b0;
    registra    = 1'b0;

    if (!habilita) begin
      estado_next = OCIOSO;
      zera_t      = 1'b1;
      zera_f      = 1'b1;
    end else begin
      case (estado_reg)
        OCIOSO: begin
          zera_t      = 1'b1;
          zera_f      = 1'b1;
          estado_next = ESPERA_SOLTA;
        end
        ESPERA_SOLTA: begin
          zera_t = 1'b1;
          zera_f = 1'b1;
          if (botoes == '0) estado_next = AGUARDA;
        end
        AGUARDA: begin
          conta_t = 1'b1;
          // A press sampled together with the last timeout count wins.
          if (botoes != '0) begin
            carrega     = 1'b1;
            zera_f      = 1'b1;
            estado_next = FILTRA;
          end else if (tempo_valor == TEMPO_FIM) begin
            estado_next = ESGOTADO;
          end
        end
        FILTRA: begin
          conta_t = 1'b1;
          if (botoes != candidato_reg) begin
            estado_next = AGUARDA;
          end else if (filtro_valor == FILTRO_FIM) begin
            registra    = 1'b1;
            estado_next = REGISTRA;
          end else begin
            conta_f = 1'b1;
          end
        end
        REGISTRA: begin
          zera_f      = 1'b1;
          estado_next = SOLTA;
        end
        SOLTA: begin
          // Any nonzero sample restarts the release window.
          if (botoes != '0) begin
            zera_f = 1'b1;
          end else if (filtro_valor == SOLTA_FIM) begin
            zera_t      = 1'b1;
            zera_f      = 1'b1;
            estado_next = AGUARDA;
          end else begin
            conta_f = 1'b1;
          end
        end
        ESGOTADO: estado_next = ESGOTADO;
        default:  estado_next = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg    <= OCIOSO;
      candidato_reg <= '0;
      jogada_reg    <= '0;
      igual_reg     <= 1'b0;
      invalida_reg  <= 1'b0;
    end else begin
      estado_reg <= estado_next;
      if (carrega) candidato_reg <= botoes;
      if (registra) begin
        jogada_reg   <= candidato_reg;
        igual_reg    <= (candidato_reg == esperado);
        invalida_reg <= !$onehot(candidato_reg);
      end
    end
  end

  assign tem_jogada = (estado_reg == REGISTRA);
  assign timeout    = (estado_reg == ESGOTADO);
  assign db_estado  = estado_reg;
  assign jogada     = jogada_reg;
  assign igual      = igual_reg;
  assign invalida   = invalida_reg;

endmodule

// File: tb/tb_leitor_jogada.sv
// Directed bench for leitor_jogada: expected plays are queued by the stimulus and
// checked by a separate monitor whenever tem_jogada pulses.
module tb_leitor_jogada;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [3:0] botoes;
  logic [3:0] esperado;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic       igual;
  logic       invalida;
  logic       timeout;
  logic [2:0] db_estado;

  typedef struct {
    logic [3:0] jogada;
    logic       igual;
    logic       invalida;
    int         ciclo;
  } previsto_t;

  previsto_t fila[$];
  previsto_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  leitor_jogada #(.DEBOUNCE(3), .TIMEOUT(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .habilita   (habilita),
    .botoes     (botoes),
    .esperado   (esperado),
    .tem_jogada (tem_jogada),
    .jogada     (jogada),
    .igual      (igual),
    .invalida   (invalida),
    .timeout    (timeout),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] req);
    checks++;
    if (atual !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", nome, cyc, atual, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Leave and re-enter the block; returns just after the edge that enters AGUARDA.
  task automatic reentra();
    botoes   = 4'b0000;
    habilita = 1'b0;
    step(1);
    chk("estado_ocioso", 32'(db_estado), 32'd0);
    habilita = 1'b1;
    step(2);
    chk("estado_aguarda", 32'(db_estado), 32'd2);
  endtask

  // Press is first sampled on the next edge; the pulse comes DEBOUNCE+1 = 4 edges later.
  task automatic pressiona(input logic [3:0] b, input logic [3:0] e,
                           input logic ig, input logic inv, input int segura);
    previsto_t p;
    esperado = e;
    botoes   = b;
    p.jogada   = b;
    p.igual    = ig;
    p.invalida = inv;
    p.ciclo    = cyc + 5;
    fila.push_back(p);
    step(segura);
    botoes = 4'b0000;
    step(6);
    chk("volta_aguarda", 32'(db_estado), 32'd2);
  endtask

  initial begin
    reset    = 1'b1;
    habilita = 1'b0;
    botoes   = 4'b0000;
    esperado = 4'b0000;

    fork
      forever begin
        @(negedge clock);
        if (tem_jogada === 1'b1) begin
          if (fila.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pulso_inesperado cyc=%0d got pulse jogada=%b expected no pulse", cyc, jogada);
          end else begin
            mon_e = fila.pop_front();
            $display("pulso cyc=%0d jogada=%b igual=%b invalida=%b", cyc, jogada, igual, invalida);
            chk("ciclo_pulso", 32'(cyc), 32'(mon_e.ciclo));
            chk("jogada", 32'(jogada), 32'(mon_e.jogada));
            chk("igual", 32'(igual), 32'(mon_e.igual));
            chk("invalida", 32'(invalida), 32'(mon_e.invalida));
          end
        end
      end
    join_none

    // Reset state, then enable: OCIOSO -> ESPERA_SOLTA -> AGUARDA.
    step(2);
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_tem_jogada", 32'(tem_jogada), 32'd0);
    chk("rst_jogada", 32'(jogada), 32'd0);
    chk("rst_igual", 32'(igual), 32'd0);
    chk("rst_invalida", 32'(invalida), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset    = 1'b0;
    habilita = 1'b1;
    step(1);
    chk("en_espera_solta", 32'(db_estado), 32'd1);
    step(1);
    chk("en_aguarda", 32'(db_estado), 32'd2);
    chk("en_timeout", 32'(timeout), 32'd0);

    // Matching, non-matching and non-one-hot plays.
    pressiona(4'b0010, 4'b0010, 1'b1, 1'b0, 10);
    reentra();
    pressiona(4'b0001, 4'b0100, 1'b0, 1'b0, 10);
    reentra();
    pressiona(4'b1001, 4'b0100, 1'b0, 1'b1, 10);

    // Glitch shorter than the debounce window.
    reentra();
    botoes = 4'b0001;
    step(2);
    botoes = 4'b0000;
    step(5);
    chk("glitch_aguarda", 32'(db_estado), 32'd2);
    chk("glitch_jogada_mantida", 32'(jogada), 32'h9);

    // Re-press before the release window completes: still one pulse.
    reentra();
    esperado = 4'b0100;
    begin
      previsto_t p;
      p.jogada = 4'b0100; p.igual = 1'b1; p.invalida = 1'b0; p.ciclo = cyc + 5;
      fila.push_back(p);
    end
    botoes = 4'b0100;
    step(10);
    botoes = 4'b0000;
    step(2);
    chk("solta_parcial", 32'(db_estado), 32'd5);
    botoes = 4'b0100;
    step(5);
    chk("solta_repress", 32'(db_estado), 32'd5);
    botoes = 4'b0000;
    step(6);
    chk("solta_fim", 32'(db_estado), 32'd2);

    // Press sampled on the same edge the count is at TIMEOUT-1 wins.
    reentra();
    step(19);
    chk("lim_antes", 32'(db_estado), 32'd2);
    pressiona(4'b1000, 4'b1000, 1'b1, 1'b0, 10);
    chk("lim_sem_timeout", 32'(timeout), 32'd0);

    // Timeout with no press, held until habilita drops.
    reentra();
    step(19);
    chk("to_ainda_nao", 32'(timeout), 32'd0);
    step(1);
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_estado", 32'(db_estado), 32'd6);
    botoes = 4'b0001;
    step(6);
    chk("to_mantem", 32'(timeout), 32'd1);
    chk("to_ignora", 32'(db_estado), 32'd6);
    botoes   = 4'b0000;
    habilita = 1'b0;
    step(1);
    chk("to_ocioso", 32'(db_estado), 32'd0);
    chk("to_limpo", 32'(timeout), 32'd0);
    chk("to_jogada_mantida", 32'(jogada), 32'h8);

    // Reset in the middle of FILTRA.
    reentra();
    esperado = 4'b0010;
    botoes   = 4'b0010;
    step(2);
    chk("rf_filtra", 32'(db_estado), 32'd3);
    reset = 1'b1;
    step(1);
    chk("rf_estado", 32'(db_estado), 32'd0);
    chk("rf_jogada", 32'(jogada), 32'd0);
    chk("rf_igual", 32'(igual), 32'd0);
    chk("rf_invalida", 32'(invalida), 32'd0);
    chk("rf_tem_jogada", 32'(tem_jogada), 32'd0);
    reset = 1'b0;
    step(8);
    chk("rf_espera_solta", 32'(db_estado), 32'd1);
    botoes = 4'b0000;
    step(3);
    chk("rf_aguarda", 32'(db_estado), 32'd2);

    chk("fila_vazia", 32'(fila.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
